i2c_passthru_bus_recover: RTL
=============================

Name: i2c_passthru_bus_recover

Overview:
- Bus-recovery transmitter: the drive-side counterpart to the passthru idle/stuck monitor.
- On request, typically when the stuck flag is asserted, it drives open-drain SCL clock pulses until the target releases SDA (max NUM_PULSES).
- It then generates a STOP condition and reports done or fail.
- Sits in the passthru datapath; its o_*_oe outputs are ORed into the pad pull-down enables.

Parameters:
F_REF_T_LOW, 38, i_f_ref ticks per SCL low/high phase, STOP setup and bus-free time; must be >=1
WIDTH_F_REF_T_LOW, 6, width of phase timer: ceil(log2(F_REF_T_LOW+1))
F_REF_T_STRETCH_MAX, 255, max i_f_ref ticks to wait for SCL to rise after release
WIDTH_F_REF_STRETCH, 8, width of stretch timer
NUM_PULSES, 9, max recovery clock pulses
WIDTH_PULSES, 4, width of pulse counter: ceil(log2(NUM_PULSES+1))

Ports:
i_clk  in  1  system clock
i_rstn  in  1  synchronous active-low reset
i_f_ref  in  1  reference timebase; rising edge (vs previous i_clk sample) = 1 tick
i_start  in  1  recovery request, level or pulse; sampled only in ST_IDLE
i_sda  in  1  SDA bus level, already synchronous to i_clk
i_scl  in  1  SCL bus level, already synchronous to i_clk
o_scl_oe  out  1  1 = pull SCL low, 0 = release
o_sda_oe  out  1  1 = pull SDA low, 0 = release
o_busy  out  1  high in every state except ST_IDLE
o_done  out  1  1-cycle pulse: STOP issued and bus observed idle
o_fail  out  1  1-cycle pulse: recovery aborted
o_pulse_cnt  out  WIDTH_PULSES  pulses issued in current/last attempt

Behaviour:
- Reset (i_rstn=0 at posedge i_clk): state=ST_IDLE, o_scl_oe=o_sda_oe=0, o_done=o_fail=0, o_pulse_cnt=0, timers=0. Reset mid-sequence releases both lines on the same edge; no STOP is generated.
- Tick: tick = i_f_ref & ~prev_f_ref. prev_f_ref is registered every cycle with no reset.
- Phase timer: loaded with F_REF_T_LOW on each state entry; decrements on tick; expires when it is 0. Stretch timer behaves the same way with F_REF_T_STRETCH_MAX.
- o_scl_oe/o_sda_oe are registered, a pure function of state; changes appear 1 cycle after the transition.
- ST_IDLE: oe=0,0. If i_start=1: o_pulse_cnt<=0 and go to ST_CLK_LOW. i_start is ignored in all other states.
- ST_CLK_LOW: scl_oe=1, sda_oe=0. On phase expiry go to ST_CLK_RISE.
- ST_CLK_RISE: scl_oe=0. Stretch timer runs.
  - If i_scl=1: go to ST_CLK_HIGH.
  - Else if stretch timer expired: o_fail, go to ST_IDLE.
- ST_CLK_HIGH: scl_oe=0. On phase expiry: o_pulse_cnt+1, then:
  - i_sda=1 → ST_STOP_LOW
  - else if new count == NUM_PULSES → o_fail, ST_IDLE
  - else → ST_CLK_LOW
- At least one pulse is always issued, even if SDA was high at start.
- ST_STOP_LOW: scl_oe=1, sda_oe=1, one phase. Then ST_STOP_RISE.
- ST_STOP_RISE: scl_oe=0, sda_oe=1. Wait for i_scl=1 (stretch timer applies, fail as in ST_CLK_RISE), then one phase (t_su_sto), then ST_STOP_BUF.
- ST_STOP_BUF: oe=0,0, one phase (t_buf). On expiry:
  - i_scl & i_sda → o_done
  - else → o_fail
  - In both cases go to ST_IDLE.
- o_done and o_fail are mutually exclusive. Each is asserted for exactly the single cycle in which the state register becomes ST_IDLE.
- Simultaneous tick and state entry: the load wins; that tick is not counted.
- o_pulse_cnt holds its value after done/fail until the next start.
- Illegal state encoding: go to ST_IDLE with lines released.

Test Plan:
- F_REF_T_LOW=4, tick every 4 clks, pull-up bus model, SDA free, pulse i_start:
  - exactly 1 SCL low pulse of 16 clks
  - STOP: SDA rises while SCL is high, 16 clks after SCL rise
  - o_done after a further 16 clks; o_pulse_cnt=1; o_fail never asserted
- Target model holds SDA low until its 3rd SCL falling edge → 4 pulses, then STOP, o_done, o_pulse_cnt=4.
- SDA held low permanently → 9 pulses, o_fail pulse, no SDA drive, oe=0,0 afterwards, o_pulse_cnt=9.
- Target stretches SCL low beyond 255 ticks after the 2nd release → o_fail within 256 ticks; o_scl_oe=0; o_pulse_cnt=1.
- i_rstn=0 during ST_STOP_RISE → o_sda_oe=o_scl_oe=0 and o_busy=0 on the same edge; no o_done/o_fail.
- i_start held high throughout the sequence → no restart until o_done; a new sequence begins the cycle after ST_IDLE is re-entered.

Source files
------------

// File: rtl/i2c_passthru_bus_recover.sv
// I2C bus-recovery transmitter: clocks SCL until the target lets go of SDA, then issues a STOP.
// The open-drain enables are registered from the state and ORed into the pad pull-downs upstream.
module i2c_passthru_bus_recover #(
  parameter int unsigned F_REF_T_LOW         = 38,
  parameter int unsigned WIDTH_F_REF_T_LOW   = 6,
  parameter int unsigned F_REF_T_STRETCH_MAX = 255,
  parameter int unsigned WIDTH_F_REF_STRETCH = 8,
  parameter int unsigned NUM_PULSES          = 9,
  parameter int unsigned WIDTH_PULSES        = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_f_ref,
  input  logic                    i_start,
  input  logic                    i_sda,
  input  logic                    i_scl,
  output logic                    o_scl_oe,
  output logic                    o_sda_oe,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_fail,
  output logic [WIDTH_PULSES-1:0] o_pulse_cnt
);

  // state        | meaning
  // ST_IDLE      | lines released, waiting for i_start
  // ST_CLK_LOW   | SCL pulled low for one phase
  // ST_CLK_RISE  | SCL released, waiting for it to rise (stretch limit)
  // ST_CLK_HIGH  | SCL high for one phase, SDA sampled at the end
  // ST_STOP_LOW  | SCL and SDA low for one phase
  // ST_STOP_RISE | SCL released, SDA low; wait for SCL then t_su_sto
  // ST_STOP_BUF  | both released for t_buf, then check bus idle
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CLK_LOW   = 3'd1,
    ST_CLK_RISE  = 3'd2,
    ST_CLK_HIGH  = 3'd3,
    ST_STOP_LOW  = 3'd4,
    ST_STOP_RISE = 3'd5,
    ST_STOP_BUF  = 3'd6
  } state_e;

  localparam logic [WIDTH_F_REF_T_LOW-1:0]   PHASE_LD   = WIDTH_F_REF_T_LOW'(F_REF_T_LOW);
  localparam logic [WIDTH_F_REF_STRETCH-1:0] STRETCH_LD = WIDTH_F_REF_STRETCH'(F_REF_T_STRETCH_MAX);
  localparam logic [WIDTH_PULSES-1:0]        PULSE_MAX  = WIDTH_PULSES'(NUM_PULSES);

  state_e                         state_q, state_d;
  logic [WIDTH_F_REF_T_LOW-1:0]   phase_q, phase_d;
  logic [WIDTH_F_REF_STRETCH-1:0] stretch_q, stretch_d;
  logic [WIDTH_PULSES-1:0]        cnt_q, cnt_d;
  logic                           scl_oe_q, sda_oe_q;
  logic                           done_q, done_d;
  logic                           fail_q, fail_d;
  logic                           f_ref_prev_q;
  logic                           tick;
  logic                           phase_exp;
  logic                           stretch_exp;

  assign tick        = i_f_ref & ~f_ref_prev_q;
  assign phase_exp   = (phase_q == '0);
  assign stretch_exp = (stretch_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    fail_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          cnt_d   = '0;
          state_d = ST_CLK_LOW;
        end
      end
      ST_CLK_LOW: begin
        if (phase_exp) state_d = ST_CLK_RISE;
      end
      ST_CLK_RISE: begin
        if (i_scl) begin
          state_d = ST_CLK_HIGH;
        end else if (stretch_exp) begin
          fail_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_CLK_HIGH: begin
        if (phase_exp) begin
          cnt_d = cnt_q + WIDTH_PULSES'(1);
          if (i_sda) begin
            state_d = ST_STOP_LOW;
          end else if (cnt_d == PULSE_MAX) begin
            fail_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_CLK_LOW;
          end
        end
      end
      ST_STOP_LOW: begin
        if (phase_exp) state_d = ST_STOP_RISE;
      end
      ST_STOP_RISE: begin
        if (!i_scl) begin
          if (stretch_exp) begin
            fail_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (phase_exp) begin
          state_d = ST_STOP_BUF;
        end
      end
      ST_STOP_BUF: begin
        if (phase_exp) begin
          done_d  = i_scl & i_sda;
          fail_d  = ~(i_scl & i_sda);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Timers reload on every state change; a tick on that same edge is dropped.
  // t_su_sto only starts counting once SCL is actually seen high.
  always_comb begin
    phase_d   = phase_q;
    stretch_d = stretch_q;
    if (state_d != state_q) begin
      phase_d   = PHASE_LD;
      stretch_d = STRETCH_LD;
    end else begin
      if (state_q == ST_STOP_RISE && !i_scl) begin
        phase_d = PHASE_LD;
      end else if (tick && !phase_exp) begin
        phase_d = phase_q - WIDTH_F_REF_T_LOW'(1);
      end
      if (tick && !stretch_exp) begin
        stretch_d = stretch_q - WIDTH_F_REF_STRETCH'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    f_ref_prev_q <= i_f_ref;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      stretch_q <= '0;
      cnt_q     <= '0;
      scl_oe_q  <= 1'b0;
      sda_oe_q  <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      stretch_q <= stretch_d;
      cnt_q     <= cnt_d;
      scl_oe_q  <= (state_q == ST_CLK_LOW) || (state_q == ST_STOP_LOW);
      sda_oe_q  <= (state_q == ST_STOP_LOW) || (state_q == ST_STOP_RISE);
      done_q    <= done_d;
      fail_q    <= fail_d;
    end
  end

  assign o_scl_oe    = scl_oe_q;
  assign o_sda_oe    = sda_oe_q;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_done      = done_q;
  assign o_fail      = fail_q;
  assign o_pulse_cnt = cnt_q;

endmodule
